// File: rtl/half_adder_resp_checker.sv
// Response checker for a half adder: it aligns the applied stimulus with the DUT's C/S outputs
// and counts checks and errors. It also tracks coverage of the four inputs and captures the first mismatch.
module half_adder_resp_checker #(
  parameter int LATENCY    = 0,
  parameter int CNT_W      = 8,
  parameter int NUM_CHECKS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stim_valid,
  input  logic [1:0]       stim_in,
  input  logic             dut_c,
  input  logic             dut_s,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [3:0]       cov_mask,
  output logic             first_err_valid,
  output logic [3:0]       first_err_vec,
  output logic [1:0]       dbg_state
);

  // Handshake: stim_valid qualifies stim_in in the cycle it is applied to the DUT; there is no
  // back-pressure. The DUT answer for that sample is expected LATENCY cycles later.

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(NUM_CHECKS - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_chk_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic [3:0]       r_cov_mask;
  logic             r_first_err_valid;
  logic [3:0]       r_first_err_vec;

  logic       w_arm;
  logic       w_flush;
  logic       w_dv;
  logic [1:0] w_dstim;
  logic       w_exp_c;
  logic       w_exp_s;
  logic       w_cmp;
  logic       w_mis;

  assign w_arm   = start && (r_state != ST_RUN);
  assign w_flush = rst || w_arm;

  generate
    if (LATENCY == 0) begin : g_nodly
      assign w_dv    = stim_valid;
      assign w_dstim = stim_in;
    end else begin : g_dly
      logic [LATENCY-1:0] r_v;
      logic [1:0]         r_s [LATENCY];

      always_ff @(posedge clk) begin
        if (w_flush) begin
          r_v <= '0;
          for (int i = 0; i < LATENCY; i++) r_s[i] <= 2'b00;
        end else begin
          r_v[0] <= stim_valid;
          r_s[0] <= stim_in;
          for (int i = 1; i < LATENCY; i++) begin
            r_v[i] <= r_v[i-1];
            r_s[i] <= r_s[i-1];
          end
        end
      end

      assign w_dv    = r_v[LATENCY-1];
      assign w_dstim = r_s[LATENCY-1];
    end
  endgenerate

  assign w_exp_c = w_dstim[1] & w_dstim[0];
  assign w_exp_s = w_dstim[1] ^ w_dstim[0];
  assign w_cmp   = (r_state == ST_RUN) && w_dv;
  assign w_mis   = (dut_c != w_exp_c) || (dut_s != w_exp_s);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state           <= ST_IDLE;
      r_chk_cnt         <= '0;
      r_err_cnt         <= '0;
      r_cov_mask        <= 4'h0;
      r_first_err_valid <= 1'b0;
      r_first_err_vec   <= 4'h0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state           <= ST_RUN;
            r_chk_cnt         <= '0;
            r_err_cnt         <= '0;
            r_cov_mask        <= 4'h0;
            r_first_err_valid <= 1'b0;
            r_first_err_vec   <= 4'h0;
          end
        end
        ST_RUN: begin
          if (w_cmp) begin
            r_chk_cnt           <= r_chk_cnt + 1'b1;
            r_cov_mask[w_dstim] <= 1'b1;
            if (w_mis) begin
              if (r_err_cnt != {CNT_W{1'b1}}) r_err_cnt <= r_err_cnt + 1'b1;
              if (!r_first_err_valid) begin
                r_first_err_valid <= 1'b1;
                r_first_err_vec   <= {w_dstim, dut_c, dut_s};
              end
            end
            // The final compare retires the run; later in-flight samples are dropped.
            if (r_chk_cnt == LP_LAST) r_state <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy            = (r_state == ST_RUN);
  assign done            = (r_state == ST_DONE);
  assign pass            = done && (r_err_cnt == '0) && (r_cov_mask == 4'hF);
  assign chk_cnt         = r_chk_cnt;
  assign err_cnt         = r_err_cnt;
  assign cov_mask        = r_cov_mask;
  assign first_err_valid = r_first_err_valid;
  assign first_err_vec   = r_first_err_vec;
  assign dbg_state       = r_state;

endmodule

// File: tb/tb_half_adder_resp_checker.sv
// Directed bench for half_adder_resp_checker: a table of four-vector runs against a combinational
// DUT model, plus hand sequences for latency, reset, re-arm and start-while-busy cases.
module tb_half_adder_resp_checker;

  localparam int CNT_W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst        = 1'b1;
  logic       start      = 1'b0;
  logic       stim_valid = 1'b0;
  logic [1:0] stim_in    = 2'b00;
  logic       fault      = 1'b0;

  // DUT models: combinational half adder (sum may be stuck at 0) and a two-register delayed one
  logic       m0_c, m0_s;
  logic [1:0] r_d1 = 2'b00, r_d2 = 2'b00;
  logic       md_c, md_s;
  assign m0_c = stim_in[1] & stim_in[0];
  assign m0_s = fault ? 1'b0 : (stim_in[1] ^ stim_in[0]);
  always @(posedge clk) begin
    r_d1 <= stim_in;
    r_d2 <= r_d1;
  end
  assign md_c = r_d2[1] & r_d2[0];
  assign md_s = r_d2[1] ^ r_d2[0];

  logic             busy0, done0, pass0, fev0_v;
  logic [CNT_W-1:0] chk0, err0;
  logic [3:0]       cov0, fev0;
  logic [1:0]       st0;
  logic             busy1, done1, pass1, fev1_v;
  logic [CNT_W-1:0] chk1, err1;
  logic [3:0]       cov1, fev1;
  logic [1:0]       st1;
  logic             busy2, done2, pass2, fev2_v;
  logic [CNT_W-1:0] chk2, err2;
  logic [3:0]       cov2, fev2;
  logic [1:0]       st2;

  half_adder_resp_checker #(.LATENCY(0), .CNT_W(CNT_W), .NUM_CHECKS(4)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .stim_valid(stim_valid), .stim_in(stim_in),
    .dut_c(m0_c), .dut_s(m0_s), .busy(busy0), .done(done0), .pass(pass0),
    .chk_cnt(chk0), .err_cnt(err0), .cov_mask(cov0), .first_err_valid(fev0_v),
    .first_err_vec(fev0), .dbg_state(st0));

  half_adder_resp_checker #(.LATENCY(1), .CNT_W(CNT_W), .NUM_CHECKS(4)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .stim_valid(stim_valid), .stim_in(stim_in),
    .dut_c(md_c), .dut_s(md_s), .busy(busy1), .done(done1), .pass(pass1),
    .chk_cnt(chk1), .err_cnt(err1), .cov_mask(cov1), .first_err_valid(fev1_v),
    .first_err_vec(fev1), .dbg_state(st1));

  half_adder_resp_checker #(.LATENCY(2), .CNT_W(CNT_W), .NUM_CHECKS(4)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .stim_valid(stim_valid), .stim_in(stim_in),
    .dut_c(md_c), .dut_s(md_s), .busy(busy2), .done(done2), .pass(pass2),
    .chk_cnt(chk2), .err_cnt(err2), .cov_mask(cov2), .first_err_valid(fev2_v),
    .first_err_vec(fev2), .dbg_state(st2));

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_q(input string name, input logic [31:0] act);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: expected queue empty, got %0h", name, act);
    end else begin
      check(name, act, exp_q.pop_front());
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic apply_vec(input logic [1:0] s);
    stim_valid = 1'b1;
    stim_in    = s;
    tick();
    stim_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    stim_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       fault;
    logic [7:0] seq;      // four stimuli, first in [7:6]
    logic [7:0] exp_err;
    logic [3:0] exp_cov;
    logic       exp_fv;
    logic [3:0] exp_fev;
    logic       exp_pass;
  } vec_t;

  vec_t tbl [5];

  initial begin
    tbl[0] = '{fault: 1'b0, seq: 8'b00_01_10_11, exp_err: 8'd0, exp_cov: 4'hF,    exp_fv: 1'b0, exp_fev: 4'b0000, exp_pass: 1'b1};
    tbl[1] = '{fault: 1'b1, seq: 8'b00_01_10_11, exp_err: 8'd2, exp_cov: 4'hF,    exp_fv: 1'b1, exp_fev: 4'b0100, exp_pass: 1'b0};
    tbl[2] = '{fault: 1'b0, seq: 8'b00_00_01_01, exp_err: 8'd0, exp_cov: 4'b0011, exp_fv: 1'b0, exp_fev: 4'b0000, exp_pass: 1'b0};
    tbl[3] = '{fault: 1'b1, seq: 8'b11_11_11_11, exp_err: 8'd0, exp_cov: 4'b1000, exp_fv: 1'b0, exp_fev: 4'b0000, exp_pass: 1'b0};
    tbl[4] = '{fault: 1'b1, seq: 8'b10_11_00_01, exp_err: 8'd2, exp_cov: 4'hF,    exp_fv: 1'b1, exp_fev: 4'b1000, exp_pass: 1'b0};

    // reset
    rst = 1'b1;
    tick();
    tick();
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_pass", pass0, 0);
    check("rst_chk", chk0, 0);
    check("rst_err", err0, 0);
    check("rst_cov", cov0, 0);
    check("rst_fev_v", fev0_v, 0);
    check("rst_fev", fev0, 0);
    check("rst_state", st0, 0);
    rst = 1'b0;
    tick();

    // table-driven runs
    for (int r = 0; r < 5; r++) begin
      fault = tbl[r].fault;
      pulse_start();
      check("arm_busy", busy0, 1);
      check("arm_chk_clr", chk0, 0);
      for (int k = 0; k < 4; k++) begin
        logic [7:0] sq;
        sq = tbl[r].seq;
        apply_vec(sq[7-2*k -: 2]);
      end
      exp_q.push_back(32'd1);
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd4);
      exp_q.push_back(32'(tbl[r].exp_err));
      exp_q.push_back(32'(tbl[r].exp_cov));
      exp_q.push_back(32'(tbl[r].exp_fv));
      exp_q.push_back(32'(tbl[r].exp_fev));
      exp_q.push_back(32'(tbl[r].exp_pass));
      check_q("row_done", done0);
      check_q("row_busy", busy0);
      check_q("row_chk", chk0);
      check_q("row_err", err0);
      check_q("row_cov", cov0);
      check_q("row_fev_v", fev0_v);
      check_q("row_fev", fev0);
      check_q("row_pass", pass0);
      idle_cycles(3);
      check("row_l2_done", done2, 1);
      check("row_l2_chk", chk2, 4);
      check("row_l2_err", err2, 0);
      check("row_l0_hold_chk", chk0, 4);
    end
    fault = 1'b0;

    // latency: 2-cycle DUT passes with LATENCY=2, fails with LATENCY=1
    pulse_start();
    apply_vec(2'b00);
    apply_vec(2'b01);
    apply_vec(2'b10);
    apply_vec(2'b11);
    idle_cycles(3);
    check("lat2_err", err2, 0);
    check("lat2_pass", pass2, 1);
    check("lat1_err_nonzero", 32'(err1 != 0), 1);
    check("lat1_pass", pass1, 0);

    // DONE: stim_valid toggling leaves counters alone
    for (int i = 0; i < 4; i++) apply_vec(2'(i));
    check("done_hold_chk", chk0, 4);
    check("done_hold_cov", cov0, 4'hF);
    check("done_hold_pass", pass0, 1);

    // reset mid-run aborts
    pulse_start();
    apply_vec(2'b00);
    apply_vec(2'b01);
    check("mid_chk2", chk0, 2);
    check("mid_pass_gated", pass0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", busy0, 0);
    check("midrst_chk", chk0, 0);
    check("midrst_cov", cov0, 0);
    check("midrst_state", st0, 0);

    // full run with a start pulse mid-run that must be ignored
    pulse_start();
    apply_vec(2'b00);
    start = 1'b1;
    apply_vec(2'b01);
    start = 1'b0;
    check("start_in_run_chk", chk0, 2);
    check("start_in_run_busy", busy0, 1);
    apply_vec(2'b10);
    apply_vec(2'b11);
    check("rerun_chk", chk0, 4);
    check("rerun_pass", pass0, 1);
    idle_cycles(3);

    // re-arm from DONE clears everything
    pulse_start();
    check("rearm_busy", busy0, 1);
    check("rearm_done", done0, 0);
    check("rearm_chk", chk0, 0);
    check("rearm_cov", cov0, 0);
    for (int k = 0; k < 4; k++) apply_vec(2'(k));
    idle_cycles(3);

    // rst together with start: rst wins
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    check("rst_start_state", st0, 0);
    check("rst_start_busy", busy0, 0);
    tick();
    check("rst_start_idle", st0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/half_adder_resp_checker.md
Name: half_adder_resp_checker

Overview:
Hardware response checker for the half-adder DUT: the receiving end of the half-adder stimulus interface. It takes the applied 2-bit stimulus {A,B} and the DUT's C and S outputs, aligns them for DUT latency, and compares every sample against the expected result (C = A&B, S = A^B). It counts checks and errors, tracks coverage of all four input combinations, captures the first failure, and reports pass/done. It sits beside the half-adder in self-checking lab builds and on-chip BIST wrappers.

Parameters:
LATENCY, 0, DUT response delay in clock cycles from stim_in to dut_c/dut_s; legal range 0..4.
CNT_W, 8, width of the check and error counters.
NUM_CHECKS, 4, number of compares in one run before DONE; legal range 1..2^CNT_W-1.

Ports:
clk  input  1  clock; all logic on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  one-cycle pulse that arms a run; honoured in IDLE or DONE, ignored in RUN.
stim_valid  input  1  stim_in is applied to the DUT this cycle.
stim_in  input  2  applied stimulus; bit1 = A, bit0 = B.
dut_c  input  1  DUT carry output.
dut_s  input  1  DUT sum output.
busy  output  1  high while in RUN.
done  output  1  high while in DONE.
pass  output  1  valid only when done is high: err_cnt==0 and cov_mask==4'hF.
chk_cnt  output  CNT_W  compares performed in this run.
err_cnt  output  CNT_W  mismatches in this run; saturates at all-ones.
cov_mask  output  4  bit k is set once stim_in==k has been checked.
first_err_valid  output  1  at least one mismatch has been captured.
first_err_vec  output  4  {A,B,dut_c,dut_s} of the first mismatch.

Behaviour:
- Reset (synchronous, active-high; takes effect at the next clock edge while rst is high): state is IDLE and the delay line is flushed. busy, done, pass, first_err_valid are 0. chk_cnt, err_cnt, cov_mask, first_err_vec are 0.
- FSM states are IDLE, RUN and DONE.
  - IDLE with start goes to RUN.
  - RUN goes to DONE on the cycle after the compare that makes chk_cnt == NUM_CHECKS.
  - DONE with start goes to RUN (re-arm).
  - There are no other transitions.
- Entering RUN (the start edge) clears chk_cnt, err_cnt, cov_mask, first_err_valid and first_err_vec, and flushes the delay line.
- Alignment: {stim_valid, stim_in} passes through a LATENCY-stage register chain.
  - The compare uses the delayed copy against the current dut_c/dut_s.
  - With LATENCY=0 the compare uses stim_in directly in the same cycle.
- A compare happens only when state is RUN and the delayed valid is 1. stim_valid is ignored outside RUN, and samples still in flight at DONE entry are dropped.
- On a compare:
  - chk_cnt increments by 1.
  - cov_mask[stim] is set.
  - A mismatch means dut_c != A&B or dut_s != A^B. On a mismatch, err_cnt increments (saturating). If first_err_valid is 0, first_err_vec is loaded and first_err_valid is set.
- All counters and flags are registered and update at the clock edge after the compare.
- pass is combinational from the registered err_cnt and cov_mask, gated by done. It holds in DONE until start or rst.
- Boundary conditions:
  - rst together with start: rst wins, state stays IDLE.
  - rst mid-run: the run is aborted and all outputs return to their reset values.
  - start in RUN: no effect.
  - Error-count saturation applies only when NUM_CHECKS exceeds 2^CNT_W-1; NUM_CHECKS is held below that, so it is a defensive case.

Test Plan:
- LATENCY=0, rst 2 cycles, start, then stim 00,01,10,11 on consecutive cycles with a correct DUT -> done rises 1 cycle after the 4th compare; chk_cnt=4, err_cnt=0, cov_mask=F, pass=1, busy=0.
- Same run with a DUT whose dut_s is forced to 0 -> err_cnt=2 (inputs 01 and 10), first_err_vec=4'b0100, first_err_valid=1, pass=0.
- Correct DUT, stim 00,00,01,01 -> chk_cnt=4, err_cnt=0, cov_mask=4'b0011, pass=0.
- LATENCY=2 with a DUT delayed by 2 registers, 4 stimuli -> err_cnt=0. Repeating the run with LATENCY=1 gives err_cnt>0.
- rst asserted after 2 compares, then start and a full 4-vector run -> counts restart from 0; final chk_cnt=4, pass=1. start pulsed mid-run -> ignored, no counter clear.
- In DONE, stim_valid toggling -> counters unchanged. A start pulse -> busy=1 next cycle, counters cleared to 0.
